// File: rtl/seg_pkg.sv
// Shared 7-segment constants and decoder FSM state encoding.
// Segment bit order is {A,B,C,D,E,F,G}, active-high; the forward encoder uses the same table.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_B     = 7'b0011111;  // lower-case b
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_D     = 7'b0111101;  // lower-case d
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_F     = 7'b1000111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic [1:0] {
      COUNT  = 2'd0,
      ACCEPT = 2'd1,
      HOLD   = 2'd2
   } seg_state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup: active-high segment pattern -> {is_blank, is_valid, nibble}.
module seg7_to_hex
   import seg_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic       is_blank_o,
   output logic       is_valid_o,
   output logic [3:0] nibble_o
);

   // Table lookup; anything not in the table and not blank is neither valid nor blank.
   always_comb begin
      is_blank_o = 1'b0;
      is_valid_o = 1'b1;
      nibble_o   = 4'h0;
      case (pattern_i)
         SEG_0:     nibble_o = 4'h0;
         SEG_1:     nibble_o = 4'h1;
         SEG_2:     nibble_o = 4'h2;
         SEG_3:     nibble_o = 4'h3;
         SEG_4:     nibble_o = 4'h4;
         SEG_5:     nibble_o = 4'h5;
         SEG_6:     nibble_o = 4'h6;
         SEG_7:     nibble_o = 4'h7;
         SEG_8:     nibble_o = 4'h8;
         SEG_9:     nibble_o = 4'h9;
         SEG_A:     nibble_o = 4'hA;
         SEG_B:     nibble_o = 4'hB;
         SEG_C:     nibble_o = 4'hC;
         SEG_D:     nibble_o = 4'hD;
         SEG_E:     nibble_o = 4'hE;
         SEG_F:     nibble_o = 4'hF;
         SEG_BLANK: begin
            is_blank_o = 1'b1;
            is_valid_o = 1'b0;
         end
         default:   is_valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_display_decoder.sv
// Two-digit multiplexed 7-segment receiver: synchronises the segment bus, waits for a pattern
// to be stable for STABLE_CYCLES samples, then decodes it into the digit selected by SegSel.
// Optional feature macro: SEG_DECODE_CHANGE_CNT_EN adds the saturating ChangeCnt output.
module seg_display_decoder
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        A,
   input  logic        B,
   input  logic        C,
   input  logic        D,
   input  logic        E,
   input  logic        F,
   input  logic        G,
   input  logic        SegSel,
   input  logic        ErrClr,
   output logic [3:0]  Digit0,
   output logic [3:0]  Digit1,
   output logic        Valid0,
   output logic        Valid1,
   output logic        Update,
   output logic        Err
`ifdef SEG_DECODE_CHANGE_CNT_EN
   ,
   output logic [15:0] ChangeCnt
`endif
);

   localparam int unsigned     CntW    = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(STABLE_CYCLES - 1);

   logic [6:0]      seg_raw;
   logic [7:0]      pat_in;
   logic [7:0]      sync1_q, pat_q, pat_prev_q;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   seg_state_e      state_q, state_d;
   logic            pat_changed, accept;
   logic [1:0][3:0] digit_q, digit_d;
   logic [1:0]      valid_q, valid_d;
   logic            err_q, err_d, upd_q, upd_d;
   logic            dec_blank, dec_valid;
   logic [3:0]      dec_nibble;

   // Inversion happens ahead of the synchroniser so reset (all zero) reads as a blank pattern.
   assign seg_raw = {A, B, C, D, E, F, G};
   assign pat_in  = {SegSel, (SEG_ACTIVE_LOW ? ~seg_raw : seg_raw)};

   // Two-flop synchroniser plus one-cycle delayed copy for change detection.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sync1_q    <= '0;
         pat_q      <= '0;
         pat_prev_q <= '0;
      end else begin
         sync1_q    <= pat_in;
         pat_q      <= sync1_q;
         pat_prev_q <= pat_q;
      end
   end

   assign pat_changed = (pat_q != pat_prev_q);
   assign cnt_inc     = cnt_q + 1'b1;

   // Stability filter FSM: count identical samples, accept once, then hold until the bus moves.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         COUNT: begin
            if (pat_changed) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == LastCnt) state_d = ACCEPT;
            end
         end
         ACCEPT: begin
            accept  = 1'b1;
            cnt_d   = '0;
            // A change landing on the accept cycle must not be lost in HOLD.
            state_d = pat_changed ? COUNT : HOLD;
         end
         HOLD: begin
            if (pat_changed) begin
               state_d = COUNT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = COUNT;
            cnt_d   = '0;
         end
      endcase
   end

   // pat_prev_q is the sample that was counted stable, even if pat_q moved this cycle.
   seg7_to_hex u_seg7_to_hex (
      .pattern_i  (pat_prev_q[6:0]),
      .is_blank_o (dec_blank),
      .is_valid_o (dec_valid),
      .nibble_o   (dec_nibble)
   );

   // Digit/valid/error next state; error set wins over ErrClr.
   always_comb begin
      digit_d = digit_q;
      valid_d = valid_q;
      err_d   = err_q & ~ErrClr;
      if (accept) begin
         if (dec_valid) begin
            digit_d[pat_prev_q[7]] = dec_nibble;
            valid_d[pat_prev_q[7]] = 1'b1;
         end else if (dec_blank) begin
            valid_d[pat_prev_q[7]] = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
      upd_d = accept && ((digit_d != digit_q) || (valid_d != valid_q));
   end

   // State, filter counter and output registers.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= COUNT;
         cnt_q   <= '0;
         digit_q <= '0;
         valid_q <= '0;
         err_q   <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         digit_q <= digit_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         upd_q   <= upd_d;
      end
   end

   assign Digit0 = digit_q[0];
   assign Digit1 = digit_q[1];
   assign Valid0 = valid_q[0];
   assign Valid1 = valid_q[1];
   assign Update = upd_q;
   assign Err    = err_q;

`ifdef SEG_DECODE_CHANGE_CNT_EN
   logic [15:0] chg_cnt_q;

   // Saturating count of Update pulses, cleared together with Err.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         chg_cnt_q <= '0;
      end else if (ErrClr) begin
         chg_cnt_q <= '0;
      end else if (upd_d && (chg_cnt_q != 16'hFFFF)) begin
         chg_cnt_q <= chg_cnt_q + 16'd1;
      end
   end

   assign ChangeCnt = chg_cnt_q;
`endif

endmodule

// File: tb/tb_seg_display_decoder.sv
// Self-checking bench for seg_display_decoder: an active-high instance and an active-low
// instance driven with the complemented pins, both compared against one behavioural model.
module tb_seg_display_decoder;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [6:0] pins;
   logic       sel;
   logic       ErrClr;

   logic [3:0] dig0, dig1, al_dig0, al_dig1;
   logic       val0, val1, upd, err, al_val0, al_val1, al_upd, al_err;
`ifdef SEG_DECODE_CHANGE_CNT_EN
   logic [15:0] ccnt, al_ccnt;
`endif

   int errors = 0;
   int checks = 0;

   logic [6:0] tbl [16];
   logic [3:0] m_dig [2];
   bit         m_val [2];
   bit         m_err;
   int         m_cc;

   always #5 Clk = ~Clk;

   seg_display_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b0)) dut (
      .Clk(Clk), .Rst(Rst),
      .A(pins[6]), .B(pins[5]), .C(pins[4]), .D(pins[3]), .E(pins[2]), .F(pins[1]), .G(pins[0]),
      .SegSel(sel), .ErrClr(ErrClr),
      .Digit0(dig0), .Digit1(dig1), .Valid0(val0), .Valid1(val1), .Update(upd), .Err(err)
`ifdef SEG_DECODE_CHANGE_CNT_EN
      , .ChangeCnt(ccnt)
`endif
   );

   seg_display_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
      .Clk(Clk), .Rst(Rst),
      .A(~pins[6]), .B(~pins[5]), .C(~pins[4]), .D(~pins[3]), .E(~pins[2]), .F(~pins[1]),
      .G(~pins[0]),
      .SegSel(sel), .ErrClr(ErrClr),
      .Digit0(al_dig0), .Digit1(al_dig1), .Valid0(al_val0), .Valid1(al_val1), .Update(al_upd),
      .Err(al_err)
`ifdef SEG_DECODE_CHANGE_CNT_EN
      , .ChangeCnt(al_ccnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_dig[0] = 4'h0; m_dig[1] = 4'h0;
      m_val[0] = 1'b0; m_val[1] = 1'b0;
      m_err = 1'b0;
      m_cc  = 0;
   endtask

   // Reference: what a stable pattern on digit s does to the display state.
   task automatic m_accept(input bit s, input logic [6:0] p, output bit chg);
      int k;
      k = -1;
      chg = 1'b0;
      for (int i = 0; i < 16; i++) if (tbl[i] == p) k = i;
      if (k >= 0) begin
         chg = (m_dig[s] != k[3:0]) || !m_val[s];
         m_dig[s] = k[3:0];
         m_val[s] = 1'b1;
      end else if (p == 7'd0) begin
         chg = m_val[s];
         m_val[s] = 1'b0;
      end else begin
         m_err = 1'b1;
      end
      if (chg && m_cc < 65535) m_cc++;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".Digit0"}, 32'(dig0), 32'(m_dig[0]));
      chk({tag, ".Digit1"}, 32'(dig1), 32'(m_dig[1]));
      chk({tag, ".Valid0"}, 32'(val0), 32'(m_val[0]));
      chk({tag, ".Valid1"}, 32'(val1), 32'(m_val[1]));
      chk({tag, ".Err"}, 32'(err), 32'(m_err));
      chk({tag, ".al_digits"}, {24'd0, al_dig1, al_dig0}, {24'd0, m_dig[1], m_dig[0]});
      chk({tag, ".al_flags"}, {29'd0, al_err, al_val1, al_val0},
          {29'd0, m_err, m_val[1], m_val[0]});
`ifdef SEG_DECODE_CHANGE_CNT_EN
      chk({tag, ".ChangeCnt"}, 32'(ccnt), 32'(m_cc));
      chk({tag, ".al_ChangeCnt"}, 32'(al_ccnt), 32'(m_cc));
`endif
   endtask

   // Apply a pattern for n cycles. Holds of 8+ cycles are long enough to be accepted and are
   // checked; zero_until > 0 also requires all outputs to stay 0 for that many cycles.
   task automatic hold(input string tag, input bit s, input logic [6:0] p, input int n,
                       input int zero_until);
      int un, ua, first;
      bit chg;
      sel  = s;
      pins = p;
      un = 0; ua = 0; first = -1;
      for (int i = 1; i <= n; i++) begin
         @(negedge Clk);
         if (upd) begin
            un++;
            if (first < 0) first = i;
         end
         if (al_upd) ua++;
         if (i <= zero_until)
            chk({tag, ".quiet"}, {26'd0, dig1, dig0, val1, val0, upd, err}, 32'd0);
      end
      if (n >= 8) begin
         m_accept(s, p, chg);
         chk({tag, ".upd_count"}, 32'(un), 32'(chg));
         chk({tag, ".al_upd_count"}, 32'(ua), 32'(chg));
         if (chg) chk({tag, ".upd_cycle"}, 32'(first), 32'd7);
         chk_state(tag);
      end
   endtask

   task automatic err_clear(input string tag);
      ErrClr = 1'b1;
      @(negedge Clk);
      ErrClr = 1'b0;
      m_err = 1'b0;
      m_cc  = 0;
      chk_state(tag);
   endtask

   initial begin
      logic [6:0] p;
      bit         s;
      bit         chg;
      int         r;

      tbl[0]  = 7'b1111110; tbl[1]  = 7'b0110000; tbl[2]  = 7'b1101101; tbl[3]  = 7'b1111001;
      tbl[4]  = 7'b0110011; tbl[5]  = 7'b1011011; tbl[6]  = 7'b1011111; tbl[7]  = 7'b1110000;
      tbl[8]  = 7'b1111111; tbl[9]  = 7'b1111011; tbl[10] = 7'b1110111; tbl[11] = 7'b0011111;
      tbl[12] = 7'b1001110; tbl[13] = 7'b0111101; tbl[14] = 7'b1001111; tbl[15] = 7'b1000111;
      m_reset();

      // 1. reset with random pins, then quiet window after release
      Rst = 1'b0; ErrClr = 1'b0; sel = 1'b1;
      pins = 7'($urandom_range(1, 127));
      repeat (3) @(negedge Clk);
      chk("reset.outputs", {25'd0, dig1, dig0, val1, val0, upd}, 32'd0);
      chk("reset.err", 32'(err), 32'd0);
      chk("reset.al_outputs", {25'd0, al_dig1, al_dig0, al_val1, al_val0, al_upd}, 32'd0);
      Rst = 1'b1;
      hold("release", 1'b1, pins, 10, 6);
      err_clear("clr0");

      // 2. digit 0 shows '1'
      hold("one", 1'b0, 7'b0110000, 10, 0);

      // 3. short '3' glitch is filtered, then '1' again
      hold("glitch", 1'b0, 7'b1111001, 2, 0);
      hold("one_again", 1'b0, 7'b0110000, 10, 0);

      // 4. alternate digits every 8 cycles
      for (int k = 0; k < 4; k++) begin
         hold("alt3", 1'b0, 7'b1111001, 8, 0);
         hold("alt7", 1'b1, 7'b1110000, 8, 0);
      end

      // 5. bad pattern sets Err, ErrClr clears it, set wins on coincidence
      hold("bad", 1'b0, 7'b1010101, 10, 0);
      err_clear("clr1");
      sel = 1'b1; pins = 7'b1100110;
      repeat (6) @(negedge Clk);
      ErrClr = 1'b1;
      @(negedge Clk);
      ErrClr = 1'b0;
      m_cc = 0;
      m_accept(1'b1, 7'b1100110, chg);
      chk("set_wins.Err", 32'(err), 32'd1);
      chk("set_wins.al_Err", 32'(al_err), 32'd1);
      repeat (3) @(negedge Clk);
      chk_state("set_wins");
      err_clear("clr2");

      // 6. 'F' then blank on digit 1; '8' on digit 0 (all-zero pins on the active-low part)
      hold("digF", 1'b1, 7'b1000111, 10, 0);
      hold("blank1", 1'b1, 7'b0000000, 10, 0);
      hold("eight", 1'b0, 7'b1111111, 10, 0);

      // randomized traffic with occasional glitches, blanks and junk
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 2) == 0)
            hold("rglitch", 1'($urandom_range(0, 1)), 7'($urandom), $urandom_range(1, 2), 0);
         s = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 19);
         if (r < 16)      p = tbl[r];
         else if (r < 18) p = 7'd0;
         else if (r < 19) p = 7'($urandom);
         else             p = tbl[$urandom_range(0, 15)];
         hold("rand", s, p, $urandom_range(8, 12), 0);
      end

      // reset in the middle of a count, then re-accept after release
      err_clear("clr3");
      hold("pre_mid", 1'b0, 7'b1111110, 10, 0);
      sel = 1'b1; pins = 7'b1011011;
      repeat (4) @(negedge Clk);
      Rst = 1'b0;
      #1;
      m_reset();
      chk("midreset.outputs", {25'd0, dig1, dig0, val1, val0, upd}, 32'd0);
      chk_state("midreset");
      @(negedge Clk);
      Rst = 1'b1;
      hold("after_mid", 1'b1, 7'b1011011, 10, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
